// File: rtl/uart_tx_fifo_sched_pkg.sv
// Shared definitions for the FIFO-to-UART transmit scheduler: state encoding and defaults.
package uart_tx_fifo_sched_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int UART_FRAME_LEN = 63;
    localparam int CNT_W_DEF      = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_WAIT_TX  = 3'd5,
        ST_GAP      = 3'd6
    } state_t;

    // Width of the inter-byte gap down-counter; never zero so declarations stay legal.
    function automatic int gap_cnt_w(input int gap_cyc);
        return (gap_cyc > 0) ? $clog2(gap_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sched.sv
// Drains one frame of FRAME_LEN bytes from the result FIFO into the UART transmitter,
// one byte in flight at a time, with an optional idle gap between bytes.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | pop one byte when the FIFO has data, else flag underrun
// CAPTURE  | latch FIFO read data into tx_data
// LAUNCH   | strobe tx_start once the transmitter is free
// WAIT_ACK | wait for the transmitter to raise tx_busy
// WAIT_TX  | wait for tx_busy to fall, then count the byte
// GAP      | idle GAP_CYC cycles before the next fetch
module uart_tx_fifo_sched
    import uart_tx_fifo_sched_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAME_LEN = UART_FRAME_LEN,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GAP_CYC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun,
    output logic [CNT_W-1:0]  byte_cnt
);

    state_t           state;
    logic             gap_done;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = byte_cnt + CNT_W'(1);
    assign busy    = (state != ST_IDLE);

    // Strobes are decoded from state so they can react to fifo_empty/tx_busy in the same
    // cycle; abort and rst suppress them so a terminated frame never pops or launches.
    assign fifo_rd_en = !rst && !abort && (state == ST_FETCH)  && !fifo_empty;
    assign tx_start   = !rst && !abort && (state == ST_LAUNCH) && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_data    <= '0;
            byte_cnt   <= '0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state    <= ST_FETCH;
                            byte_cnt <= '0;
                            underrun <= 1'b0;
                        end
                    end
                    ST_FETCH: begin
                        if (fifo_empty) underrun <= 1'b1;
                        else            state    <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        tx_data <= fifo_rd_data;
                        state   <= ST_LAUNCH;
                    end
                    ST_LAUNCH: begin
                        if (!tx_busy) state <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (tx_busy) state <= ST_WAIT_TX;
                    end
                    ST_WAIT_TX: begin
                        if (!tx_busy) begin
                            byte_cnt <= cnt_inc;
                            if (cnt_inc == CNT_W'(FRAME_LEN)) begin
                                frame_done <= 1'b1;
                                state      <= ST_IDLE;
                            end else if (GAP_CYC > 0) begin
                                state <= ST_GAP;
                            end else begin
                                state <= ST_FETCH;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_done) state <= ST_FETCH;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    generate
        if (GAP_CYC > 0) begin : g_gap
            localparam int GAP_W = gap_cnt_w(GAP_CYC);
            logic [GAP_W-1:0] gap_cnt;

            // Preloaded outside GAP so the first GAP cycle already counts.
            always_ff @(posedge clk) begin
                if (rst || state != ST_GAP) gap_cnt <= GAP_W'(GAP_CYC - 1);
                else if (gap_cnt != '0)     gap_cnt <= gap_cnt - GAP_W'(1);
            end

            assign gap_done = (gap_cnt == '0);
        end else begin : g_no_gap
            assign gap_done = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Directed bench for uart_tx_fifo_sched: FIFO and transmitter models around a 63-byte
// no-gap instance and a 3-byte instance with a 4-cycle inter-byte gap.
module tb_uart_tx_fifo_sched;

    localparam int TX_CYC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start[2]        = '{1'b0, 1'b0};
    logic abort[2]        = '{1'b0, 1'b0};
    logic fifo_empty[2];
    logic fifo_rd_en[2];
    logic tx_busy[2];
    logic tx_start[2];
    logic busy[2];
    logic frame_done[2];
    logic underrun[2];
    logic [7:0] fifo_rd_data[2] = '{8'h00, 8'h00};
    logic [7:0] tx_data[2];
    logic [5:0] byte_cnt[2];

    logic [7:0] mem[2][256];
    int wr_ptr[2]   = '{0, 0};
    int rd_ptr[2]   = '{0, 0};
    int tx_timer[2] = '{0, 0};
    logic busy_q[2] = '{1'b0, 1'b0};

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int n_tx[2]    = '{0, 0};
    int n_rd[2]    = '{0, 0};
    int n_fall[2]  = '{0, 0};
    int n_fd[2]    = '{0, 0};
    int rd_viol[2] = '{0, 0};
    int st_viol[2] = '{0, 0};
    int fd_cyc[2]  = '{0, 0};
    logic [7:0] tx_log[2][256];
    int rd_cyc[2][256];
    int fall_cyc[2][256];
    int txs_cyc[2][256];

    always #5 clk = ~clk;

    uart_tx_fifo_sched #(.DATA_W(8), .FRAME_LEN(63), .CNT_W(6), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]), .fifo_rd_data(fifo_rd_data[0]),
        .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .underrun(underrun[0]), .byte_cnt(byte_cnt[0])
    );

    uart_tx_fifo_sched #(.DATA_W(8), .FRAME_LEN(3), .CNT_W(6), .GAP_CYC(4)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]), .fifo_rd_data(fifo_rd_data[1]),
        .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .underrun(underrun[1]), .byte_cnt(byte_cnt[1])
    );

    assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
    assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
    assign tx_busy[0]    = (tx_timer[0] != 0);
    assign tx_busy[1]    = (tx_timer[1] != 0);

    // FIFO, transmitter and event monitor for both instances; cyc tags the cycle just ending.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (fifo_rd_en[g]) begin
                if (fifo_empty[g]) rd_viol[g]++;
                fifo_rd_data[g] <= mem[g][rd_ptr[g][7:0]];
                rd_ptr[g] <= rd_ptr[g] + 1;
                if (n_rd[g] < 256) rd_cyc[g][n_rd[g]] = cyc;
                n_rd[g]++;
            end
            if (tx_start[g]) begin
                if (tx_busy[g]) st_viol[g]++;
                if (n_tx[g] < 256) begin
                    tx_log[g][n_tx[g]]  = tx_data[g];
                    txs_cyc[g][n_tx[g]] = cyc;
                end
                n_tx[g]++;
                tx_timer[g] <= TX_CYC;
            end else if (tx_timer[g] != 0) begin
                tx_timer[g] <= tx_timer[g] - 1;
            end
            if (busy_q[g] && !tx_busy[g]) begin
                if (n_fall[g] < 256) fall_cyc[g][n_fall[g]] = cyc;
                n_fall[g]++;
            end
            busy_q[g] <= tx_busy[g];
            if (frame_done[g]) begin
                n_fd[g]++;
                fd_cyc[g] = cyc;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int g, input logic [7:0] d);
        mem[g][wr_ptr[g][7:0]] = d;
        wr_ptr[g]++;
    endtask

    task automatic flush(input int g);
        wr_ptr[g] = rd_ptr[g];
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        step(1);
        start[g] = 1'b0;
    endtask

    task automatic pulse_abort(input int g);
        abort[g] = 1'b1;
        step(1);
        abort[g] = 1'b0;
    endtask

    function automatic int probe(input int which, input int g);
        case (which)
            0:       return n_tx[g];
            1:       return n_fall[g];
            2:       return n_fd[g];
            default: return n_rd[g];
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int g, input int target, input int budget,
                            input string name);
        int k;
        k = 0;
        while (probe(which, g) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (probe(which, g) < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: count %0d required %0d", name, probe(which, g), target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
        total++; if (fifo_rd_en[0] !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en[0]); end
        total++; if (tx_start[0] !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start[0]); end
        total++; if (frame_done[0] !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done[0]); end
        total++; if (underrun[0] !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun[0]); end
        total++; if (byte_cnt[0] !== 6'd0) begin bad++; $display("FAIL rst_byte_cnt: got %0d want 0", byte_cnt[0]); end
        total++; if (tx_data[0] !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data[0]); end
    endtask

    task automatic test_latency();
        int c0, b_rd, b_tx, b_fall;
        push(0, 8'hA5);
        b_rd = n_rd[0]; b_tx = n_tx[0]; b_fall = n_fall[0];
        c0 = cyc;
        pulse_start(0);
        wait_cnt(0, 0, b_tx + 1, 20, "lat_tx");
        total++; if (rd_cyc[0][b_rd] !== c0 + 1) begin bad++; $display("FAIL lat_rd_en: cycle %0d want %0d", rd_cyc[0][b_rd], c0 + 1); end
        total++; if (txs_cyc[0][b_tx] !== c0 + 3) begin bad++; $display("FAIL lat_tx_start: cycle %0d want %0d", txs_cyc[0][b_tx], c0 + 3); end
        total++; if (tx_log[0][b_tx] !== 8'hA5) begin bad++; $display("FAIL lat_tx_data: got %h want a5", tx_log[0][b_tx]); end
        wait_cnt(1, 0, b_fall + 1, 30, "lat_fall");
        step(3);
        total++; if (byte_cnt[0] !== 6'd1) begin bad++; $display("FAIL lat_byte_cnt: got %0d want 1", byte_cnt[0]); end
        total++; if (underrun[0] !== 1'b1) begin bad++; $display("FAIL lat_underrun: got %b want 1", underrun[0]); end
        pulse_abort(0);
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL lat_abort_busy: got %b want 0", busy[0]); end
        total++; if (byte_cnt[0] !== 6'd1) begin bad++; $display("FAIL lat_abort_cnt: got %0d want 1", byte_cnt[0]); end
    endtask

    task automatic test_full_frame();
        int b_tx, b_rd, b_fall, b_fd;
        logic [7:0] exp_d;
        for (int i = 0; i < 63; i++) push(0, 8'(i));
        b_tx = n_tx[0]; b_rd = n_rd[0]; b_fall = n_fall[0]; b_fd = n_fd[0];
        pulse_start(0);
        total++; if (underrun[0] !== 1'b0) begin bad++; $display("FAIL full_underrun_clr: got %b want 0", underrun[0]); end
        wait_cnt(2, 0, b_fd + 1, 2000, "full_done");
        step(5);
        total++; if (n_tx[0] - b_tx !== 63) begin bad++; $display("FAIL full_tx_count: got %0d want 63", n_tx[0] - b_tx); end
        for (int i = 0; i < 63; i++) begin
            exp_d = 8'(i);
            total++;
            if (tx_log[0][b_tx + i] !== exp_d) begin
                bad++;
                $display("FAIL full_data[%0d]: got %h want %h", i, tx_log[0][b_tx + i], exp_d);
            end
        end
        total++; if (n_fd[0] - b_fd !== 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", n_fd[0] - b_fd); end
        total++; if (fd_cyc[0] !== fall_cyc[0][b_fall + 62] + 1) begin bad++; $display("FAIL full_done_cycle: got %0d want %0d", fd_cyc[0], fall_cyc[0][b_fall + 62] + 1); end
        total++; if (rd_cyc[0][b_rd + 1] - fall_cyc[0][b_fall] !== 1) begin bad++; $display("FAIL full_no_gap: got %0d want 1", rd_cyc[0][b_rd + 1] - fall_cyc[0][b_fall]); end
        total++; if (byte_cnt[0] !== 6'd63) begin bad++; $display("FAIL full_byte_cnt: got %0d want 63", byte_cnt[0]); end
        total++; if (underrun[0] !== 1'b0) begin bad++; $display("FAIL full_underrun: got %b want 0", underrun[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL full_busy: got %b want 0", busy[0]); end
        total++; if (n_rd[0] - b_rd !== 63) begin bad++; $display("FAIL full_rd_count: got %0d want 63", n_rd[0] - b_rd); end
    endtask

    task automatic test_underrun();
        int b_tx, b_rd, b_fall;
        b_tx = n_tx[0]; b_rd = n_rd[0]; b_fall = n_fall[0];
        pulse_start(0);
        step(20);
        total++; if (n_rd[0] - b_rd !== 0) begin bad++; $display("FAIL und_no_rd: got %0d reads want 0", n_rd[0] - b_rd); end
        total++; if (underrun[0] !== 1'b1) begin bad++; $display("FAIL und_flag: got %b want 1", underrun[0]); end
        total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL und_busy: got %b want 1", busy[0]); end
        push(0, 8'h5A);
        wait_cnt(0, 0, b_tx + 1, 20, "und_tx");
        total++; if (tx_log[0][b_tx] !== 8'h5A) begin bad++; $display("FAIL und_data: got %h want 5a", tx_log[0][b_tx]); end
        wait_cnt(1, 0, b_fall + 1, 30, "und_fall");
        step(3);
        total++; if (byte_cnt[0] !== 6'd1) begin bad++; $display("FAIL und_byte_cnt: got %0d want 1", byte_cnt[0]); end
        pulse_abort(0);
        step(2);
        total++; if (underrun[0] !== 1'b1) begin bad++; $display("FAIL und_sticky: got %b want 1", underrun[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL und_abort_busy: got %b want 0", busy[0]); end
    endtask

    task automatic test_abort();
        int b_tx, b_fd;
        for (int i = 0; i < 10; i++) push(0, 8'h10 + 8'(i));
        b_tx = n_tx[0]; b_fd = n_fd[0];
        pulse_start(0);
        total++; if (underrun[0] !== 1'b0) begin bad++; $display("FAIL abt_underrun_clr: got %b want 0", underrun[0]); end
        total++; if (byte_cnt[0] !== 6'd0) begin bad++; $display("FAIL abt_cnt_clr: got %0d want 0", byte_cnt[0]); end
        wait_cnt(0, 0, b_tx + 6, 200, "abt_tx6");
        step(2);
        pulse_abort(0);
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL abt_idle: got %b want 0", busy[0]); end
        total++; if (byte_cnt[0] !== 6'd5) begin bad++; $display("FAIL abt_byte_cnt: got %0d want 5", byte_cnt[0]); end
        total++; if (tx_log[0][b_tx + 5] !== 8'h15) begin bad++; $display("FAIL abt_data6: got %h want 15", tx_log[0][b_tx + 5]); end
        step(20);
        total++; if (n_fd[0] !== b_fd) begin bad++; $display("FAIL abt_no_done: got %0d want %0d", n_fd[0], b_fd); end
        total++; if (n_tx[0] - b_tx !== 6) begin bad++; $display("FAIL abt_no_launch: got %0d want 6", n_tx[0] - b_tx); end
        total++; if (byte_cnt[0] !== 6'd5) begin bad++; $display("FAIL abt_cnt_hold: got %0d want 5", byte_cnt[0]); end
        pulse_start(0);
        total++; if (byte_cnt[0] !== 6'd0) begin bad++; $display("FAIL abt_restart_cnt: got %0d want 0", byte_cnt[0]); end
        pulse_abort(0);
        flush(0);
    endtask

    task automatic test_gap();
        for (int i = 0; i < 4; i++) push(1, 8'h31 + 8'(i));
        pulse_start(1);
        wait_cnt(2, 1, 1, 300, "gap_done");
        step(5);
        total++; if (n_tx[1] !== 3) begin bad++; $display("FAIL gap_tx_count: got %0d want 3", n_tx[1]); end
        total++; if (n_rd[1] !== 3) begin bad++; $display("FAIL gap_rd_count: got %0d want 3", n_rd[1]); end
        total++; if (tx_log[1][2] !== 8'h33) begin bad++; $display("FAIL gap_data3: got %h want 33", tx_log[1][2]); end
        total++; if (rd_cyc[1][1] - fall_cyc[1][0] !== 5) begin bad++; $display("FAIL gap_len1: got %0d want 5", rd_cyc[1][1] - fall_cyc[1][0]); end
        total++; if (rd_cyc[1][2] - fall_cyc[1][1] !== 5) begin bad++; $display("FAIL gap_len2: got %0d want 5", rd_cyc[1][2] - fall_cyc[1][1]); end
        total++; if (fd_cyc[1] !== fall_cyc[1][2] + 1) begin bad++; $display("FAIL gap_done_cycle: got %0d want %0d", fd_cyc[1], fall_cyc[1][2] + 1); end
        total++; if (byte_cnt[1] !== 6'd3) begin bad++; $display("FAIL gap_byte_cnt: got %0d want 3", byte_cnt[1]); end
        total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL gap_busy: got %b want 0", busy[1]); end
    endtask

    task automatic test_misc();
        int b_tx, b_fall, b_rd;
        for (int i = 0; i < 4; i++) push(0, 8'h41 + 8'(i));
        b_tx = n_tx[0]; b_fall = n_fall[0];
        pulse_start(0);
        wait_cnt(1, 0, b_fall + 1, 40, "misc_fall");
        step(2);
        pulse_start(0);
        total++; if (byte_cnt[0] !== 6'd1) begin bad++; $display("FAIL misc_start_busy_cnt: got %0d want 1", byte_cnt[0]); end
        total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL misc_start_busy: got %b want 1", busy[0]); end
        wait_cnt(0, 0, b_tx + 2, 40, "misc_tx2");
        step(3);
        rst = 1'b1;
        step(1);
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL misc_rst_busy: got %b want 0", busy[0]); end
        total++; if (byte_cnt[0] !== 6'd0) begin bad++; $display("FAIL misc_rst_cnt: got %0d want 0", byte_cnt[0]); end
        total++; if (tx_data[0] !== 8'h00) begin bad++; $display("FAIL misc_rst_data: got %h want 00", tx_data[0]); end
        total++; if ({tx_start[0], fifo_rd_en[0], frame_done[0], underrun[0]} !== 4'b0000) begin bad++; $display("FAIL misc_rst_strobes: got %b want 0000", {tx_start[0], fifo_rd_en[0], frame_done[0], underrun[0]}); end
        rst = 1'b0;
        step(2);
        b_rd = n_rd[0];
        start[0] = 1'b1;
        abort[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL misc_abort_start: got %b want 0", busy[0]); end
        step(5);
        total++; if (n_rd[0] !== b_rd) begin bad++; $display("FAIL misc_abort_start_rd: got %0d want %0d", n_rd[0], b_rd); end
        total++; if (st_viol[0] + st_viol[1] !== 0) begin bad++; $display("FAIL tx_start_while_busy: got %0d want 0", st_viol[0] + st_viol[1]); end
        total++; if (rd_viol[0] + rd_viol[1] !== 0) begin bad++; $display("FAIL rd_while_empty: got %0d want 0", rd_viol[0] + rd_viol[1]); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_latency();
        test_full_frame();
        test_underrun();
        test_abort();
        test_gap();
        test_misc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
